// File: rtl/decoder_pkg.sv
// Shared types for the 2-to-4 decoder stream: code/line widths, the FIFO entry
// layout, the occupancy state and the one-hot decode helper.
package decoder_pkg;

  localparam int CODE_W = 2;
  localparam int LINES  = 4;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [LINES-1:0]  lines_t;

  typedef struct packed {
    code_t code;
    logic  en;
  } entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_t;

  function automatic lines_t onehot(input entry_t e);
    lines_t l;
    l = '0;
    if (e.en) l[e.code] = 1'b1;
    return l;
  endfunction

endpackage

// File: rtl/decoder_fifo.sv
// Small power-of-two FIFO of decoder entries with ready/valid on both sides.
// Ready and valid come only from registered occupancy, never from the other side.
module decoder_fifo
  import decoder_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_valid_i,
  output logic                     push_ready_o,
  input  entry_t                   push_data_i,
  output logic                     pop_valid_o,
  input  logic                     pop_ready_i,
  output entry_t                   head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [OCC_W-1:0]   count_q, count_d;
  occ_t               occ;
  logic               pushFire, popFire;

  // State register: storage is cleared too so nothing stale survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      if (pushFire) mem_q[wrPtr_q] <= push_data_i;
    end
  end

  always_comb begin
    pushFire = push_valid_i && push_ready_o;
    popFire  = pop_valid_o && pop_ready_i;
    wrPtr_d  = wrPtr_q + PTR_W'(pushFire);
    rdPtr_d  = rdPtr_q + PTR_W'(popFire);
    count_d  = count_q + OCC_W'(pushFire) - OCC_W'(popFire);
  end

  always_comb begin
    if (count_q == '0)                occ = OCC_EMPTY;
    else if (count_q == OCC_W'(DEPTH)) occ = OCC_FULL;
    else                              occ = OCC_PARTIAL;
    push_ready_o = (occ != OCC_FULL);
    pop_valid_o  = (occ != OCC_EMPTY);
    head_o       = mem_q[rdPtr_q];
    count_o      = count_q;
  end

endmodule

// File: rtl/decoder2to4_stream.sv
// Registered 2-to-4 decoder behind a small FIFO. Define DECODER_STATS_EN to add
// saturating per-line pop counters (stat_clr / hit_cnt ports, CNT_W parameter).
module decoder2to4_stream
  import decoder_pkg::*;
#(
  parameter int DEPTH = 2
`ifdef DECODER_STATS_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CODE_W-1:0]        in_code,
  input  logic                     in_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LINES-1:0]         out_lines,
  output logic [$clog2(DEPTH):0]   count
`ifdef DECODER_STATS_EN
  ,
  input  logic                     stat_clr,
  output logic [LINES*CNT_W-1:0]   hit_cnt
`endif
);

  entry_t pushEntry;
  entry_t headEntry;

  assign pushEntry = '{code: in_code, en: in_en};

  decoder_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid_i (in_valid),
    .push_ready_o (in_ready),
    .push_data_i  (pushEntry),
    .pop_valid_o  (out_valid),
    .pop_ready_i  (out_ready),
    .head_o       (headEntry),
    .count_o      (count)
  );

  assign out_lines = out_valid ? onehot(headEntry) : '0;

`ifdef DECODER_STATS_EN
  logic [CNT_W-1:0] hitCnt_q [LINES];
  logic [CNT_W-1:0] hitCnt_d [LINES];
  logic             popFire;

  assign popFire = out_valid && out_ready;

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_comb begin
    for (int k = 0; k < LINES; k++) begin
      hitCnt_d[k] = hitCnt_q[k];
      if (stat_clr)
        hitCnt_d[k] = '0;
      else if (popFire && out_lines[k] && (hitCnt_q[k] != '1))
        hitCnt_d[k] = hitCnt_q[k] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LINES; k++) hitCnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < LINES; k++) hitCnt_q[k] <= hitCnt_d[k];
    end
  end

  for (genvar g = 0; g < LINES; g++) begin : g_hit
    assign hit_cnt[g*CNT_W +: CNT_W] = hitCnt_q[g];
  end
`endif

endmodule

// File: tb/tb_decoder2to4_stream.sv
// Directed bench for decoder2to4_stream with a scoreboard of expected line
// vectors; define DECODER_STATS_EN to also exercise the hit counters.
module tb_decoder2to4_stream;

  localparam int DEPTH = 2;
`ifdef DECODER_STATS_EN
  localparam int CNT_W = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_code = '0;
  logic       in_en = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_lines;
  logic [1:0] count;
`ifdef DECODER_STATS_EN
  logic             stat_clr = 1'b0;
  logic [4*CNT_W-1:0] hit_cnt;
`endif

  logic [3:0] sbQ[$];
  int passCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  decoder2to4_stream #(
    .DEPTH(DEPTH)
`ifdef DECODER_STATS_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_en     (in_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lines (out_lines),
    .count     (count)
`ifdef DECODER_STATS_EN
    , .stat_clr (stat_clr)
    , .hit_cnt  (hit_cnt)
`endif
  );

  function automatic logic [3:0] model(input logic [1:0] code, input logic en);
    return en ? (4'b0001 << code) : 4'b0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic valid, input logic [1:0] code,
                               input logic en, input logic ready);
    in_valid  = valid;
    in_code   = code;
    in_en     = en;
    out_ready = ready;
  endtask

  // One clock: score pops and pushes at the falling edge, then move past the rise.
  task automatic tick();
    logic [3:0] expLines;
    @(negedge clk);
    if (out_valid && out_ready) begin
      expLines = (sbQ.size() != 0) ? sbQ.pop_front() : 4'bxxxx;
      checkOutput("pop_lines", {28'd0, out_lines}, {28'd0, expLines});
    end
    if (in_valid && in_ready) sbQ.push_back(model(in_code, in_en));
    @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] start");
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_lines", {28'd0, out_lines}, 32'd0);
    checkOutput("rst_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_count", {30'd0, count}, 32'd0);
    tick();
    checkOutput("idle_valid", {31'd0, out_valid}, 32'd0);

    // Streaming codes 0..3: each one shows up the cycle after its push.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'(i), 1'b1, 1'b1);
      tick();
      checkOutput("stream_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("stream_lines", {28'd0, out_lines}, {28'd0, model(2'(i), 1'b1)});
      checkOutput("stream_count", {30'd0, count}, 32'd1);
    end
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    checkOutput("stream_drain", {30'd0, count}, 32'd0);

    // Backpressure: fill to DEPTH, third entry held by the source.
    applyStimulus(1'b1, 2'd1, 1'b1, 1'b0);
    tick();
    checkOutput("bp_ready1", {31'd0, in_ready}, 32'd1);
    applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
    tick();
    checkOutput("bp_ready2", {31'd0, in_ready}, 32'd0);
    checkOutput("bp_count2", {30'd0, count}, 32'd2);
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b0);
    tick();
    checkOutput("bp_full_hold", {30'd0, count}, 32'd2);
    checkOutput("bp_lines_stable", {28'd0, out_lines}, 32'h2);
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b1);
    tick();
    tick();
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    checkOutput("bp_drain", {30'd0, count}, 32'd0);
    checkOutput("bp_sb_empty", sbQ.size(), 32'd0);

    // Concurrent push/pop at count 1 across pointer wraps.
    applyStimulus(1'b1, 2'd0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
      tick();
      checkOutput("pp_count", {30'd0, count}, 32'd1);
    end
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    checkOutput("pp_drain", {30'd0, count}, 32'd0);

    // Disabled decode: valid entry with all-zero lines; unpushed X ignored.
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 2'bxx, 1'bx, 1'b0);
    tick();
    checkOutput("en0_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("en0_lines", {28'd0, out_lines}, 32'd0);
    checkOutput("x_count", {30'd0, count}, 32'd1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    checkOutput("en0_drain", {30'd0, count}, 32'd0);

    // Reset mid-stream takes effect before any clock edge.
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b0);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("arst_lines", {28'd0, out_lines}, 32'd0);
    checkOutput("arst_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("arst_count", {30'd0, count}, 32'd0);
    sbQ.delete();
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 2'd1, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    checkOutput("post_rst_drain", {30'd0, count}, 32'd0);

`ifdef DECODER_STATS_EN
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    checkOutput("stat_cleared", 32'(hit_cnt), 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 2'd1, 1'b1, 1'b1);
      tick();
    end
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    checkOutput("stat_sat", 32'(hit_cnt[CNT_W +: CNT_W]), 32'd3);
    checkOutput("stat_other", 32'(hit_cnt[2*CNT_W +: CNT_W]), 32'd0);
    applyStimulus(1'b1, 2'd1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    checkOutput("stat_clr_pop", 32'(hit_cnt[CNT_W +: CNT_W]), 32'd0);
`endif

    checkOutput("final_sb_empty", sbQ.size(), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/decoder2to4_stream.md
Name: decoder2to4_stream

Overview:
- Registered 2-to-4 line decoder with valid/ready handshake on both sides. It is the inverse of the team's 4-to-2 encoder.
- Accepts a stream of 2-bit codes plus an enable bit and buffers them in a small FIFO.
- Presents a one-hot 4-bit line vector per entry.
- Sits downstream of encoder logic, restoring one-hot select lines for the consumer.

Parameters:
- DEPTH, 2, FIFO entries; power of 2, at least 2.
- CNT_W, 8, width of each per-line hit counter (used only with DECODER_STATS_EN).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  code/en valid
- in_ready  out  1  block can accept
- in_code  in  2  binary code to decode (bit1 = o1, bit0 = o0 sense of encoder)
- in_en  in  1  decode enable; 0 yields all-zero lines
- out_valid  out  1  out_lines valid
- out_ready  in  1  consumer accepts
- out_lines  out  4  one-hot lines o3..o0
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async assert, sync-released by the surrounding reset tree):
  - FIFO empty, count = 0, pointers = 0.
  - out_valid = 0, out_lines = 4'b0000, in_ready = 1.
  - Stats counters = 0.
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- in_ready = (count != DEPTH); registered-derived, with no combinational path from out_ready.
- out_valid = (count != 0).
- out_lines:
  - Empty: 4'b0000.
  - Head entry with en = 1: 4'b0001 << code.
  - Head entry with en = 0: 4'b0000.
  - Always registered/FIFO-sourced, never a combinational pass-through of in_code.
- Latency: entry accepted at edge N is visible on out_lines/out_valid after edge N (cycle N+1). There is no same-cycle bypass.
- Occupancy state (derived from count): EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
  - EMPTY: push -> PARTIAL (or FULL if DEPTH = 1, disallowed); pop is impossible.
  - PARTIAL: push only -> count+1; pop only -> count-1; push and pop -> count unchanged, both pointers advance.
  - FULL: push blocked (in_ready = 0); pop -> PARTIAL.
- Pointers wrap modulo DEPTH.
- in_valid while in_ready = 0: no state change; the source must hold data (AXI-style).
- out_valid, once high, stays high with out_lines stable until the pop completes.
- in_code/in_en of non-pushed cycles are ignored. X on unpushed inputs must not propagate.
- Reset mid-operation: all stored entries are discarded immediately, outputs go to reset values asynchronously, and no partial pop is reported.

Optional Feature:
- Macro: DECODER_STATS_EN
- Defined:
  - Adds ports stat_clr (in, 1) and hit_cnt (out, 4*CNT_W). Slice k counts pops whose out_lines[k] = 1.
  - Counters saturate at all-ones and do not wrap.
  - stat_clr synchronously zeroes all counters and takes priority over a same-cycle increment.
  - Pops with en = 0 increment nothing.
- Undefined: the ports and counters are absent and the datapath behaviour is identical.

Decomposition:
- Package decoder_pkg:
  - Constants CODE_W = 2 and LINES = 4.
  - Typedef code_t [CODE_W-1:0] and typedef lines_t [LINES-1:0].
  - Packed struct entry_t {code_t code; logic en;}.
  - Function onehot(entry_t) returning lines_t.
- Sub-module decoder_fifo: generic entry_t FIFO holding storage, pointers, count, and ready/valid.
- Top decoder2to4_stream: instantiates decoder_fifo and applies onehot on the head entry, plus the optional stats logic.

Test Plan:
- Reset then idle: out_valid = 0, out_lines = 0000, in_ready = 1, count = 0. Assert rst_n low mid-stream: outputs return to these values without waiting for a clock edge.
- Push codes 0, 1, 2, 3 (en = 1) with out_ready = 1: out_lines sequence 0001, 0010, 0100, 1000, each one cycle after its push.
- out_ready = 0, push 3 entries with DEPTH = 2: in_ready drops after the 2nd push and count = 2. The 3rd is held by the source. Release out_ready: order is preserved and count returns to 0.
- Simultaneous push/pop at count = 1 for 10 cycles: count stays 1, pointers wrap, no entry lost or duplicated.
- Push code 2 with en = 0: out_valid = 1, out_lines = 0000.
- DECODER_STATS_EN, CNT_W = 2: pop code 1 five times -> hit_cnt[1] = 3 (saturated). Pulse stat_clr on the same cycle as a pop -> hit_cnt[1] = 0.
